// File: rtl/dual_grant_arbiter_pkg.sv
// Shared types, defaults and ID/one-hot helpers for the dual-channel grant arbiter.
package dual_grant_arbiter_pkg;

    localparam int N_DEF        = 12;
    localparam int IDW_DEF      = 4;
    localparam int MAX_HOLD_DEF = 16;

    // Helper functions work on a wide fixed container; callers size-cast to their own N/IDW.
    localparam int MAX_N   = 64;
    localparam int MAX_IDW = 7;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } chan_state_t;

    localparam logic [MAX_IDW-1:0] ID_NONE = 7'd0;

    function automatic logic [MAX_N-1:0] id_to_onehot(input logic [MAX_IDW-1:0] id);
        logic [MAX_N-1:0] oh;
        oh = '0;
        for (int i = 0; i < MAX_N; i++) begin
            oh[i] = (id == MAX_IDW'(i + 1));
        end
        return oh;
    endfunction

    function automatic logic [MAX_IDW-1:0] onehot_to_id(input logic [MAX_N-1:0] oh);
        logic [MAX_IDW-1:0] id;
        id = ID_NONE;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) begin
                id = MAX_IDW'(i + 1);
            end else begin
                id = id;
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/dual_grant_arbiter_dual_prio_enc.sv
// Combinational dual priority encoder: IDs of the highest and second-highest set bits (0 = none).
module dual_prio_enc
    import dual_grant_arbiter_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int IDW = IDW_DEF
) (
    input  logic [N-1:0]   vec,
    output logic [IDW-1:0] first,
    output logic [IDW-1:0] second
);

    logic [N-1:0] first_oh_s;
    logic [N-1:0] rest_s;
    logic [N-1:0] second_oh_s;

    // Isolate the highest set bit, then the highest of what remains.
    always_comb begin
        first_oh_s  = '0;
        second_oh_s = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                first_oh_s    = '0;
                first_oh_s[i] = 1'b1;
            end else begin
                first_oh_s = first_oh_s;
            end
        end
        rest_s = vec & ~first_oh_s;
        for (int i = 0; i < N; i++) begin
            if (rest_s[i]) begin
                second_oh_s    = '0;
                second_oh_s[i] = 1'b1;
            end else begin
                second_oh_s = second_oh_s;
            end
        end
        first  = IDW'(onehot_to_id(MAX_N'(first_oh_s)));
        second = IDW'(onehot_to_id(MAX_N'(second_oh_s)));
    end

endmodule

// File: rtl/dual_grant_arbiter.sv
// Two-channel arbiter: 12 requesters, highest ID first, grants held until done, request drop or hold limit.
module dual_grant_arbiter
    import dual_grant_arbiter_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int IDW      = IDW_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   done,
    output logic           gnt_a_vld,
    output logic [IDW-1:0] gnt_a_id,
    output logic           gnt_b_vld,
    output logic [IDW-1:0] gnt_b_id,
    output logic [N-1:0]   gnt_vec,
    output logic [1:0]     timeout
);

    localparam int              CNT_W    = $clog2(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    chan_state_t      state_r    [2];
    chan_state_t      state_nx_s [2];
    logic [IDW-1:0]   id_r       [2];
    logic [IDW-1:0]   id_nx_s    [2];
    logic [IDW-1:0]   alloc_id_s [2];
    logic [CNT_W-1:0] cnt_r      [2];
    logic [CNT_W-1:0] cnt_nx_s   [2];

    logic [N-1:0]   bar_r, bar_nx_s;
    logic [N-1:0]   gnt_vec_r, gnt_vec_nx_s;
    logic [N-1:0]   elig_s, held_oh_s;
    logic [1:0]     timeout_r, timeout_nx_s;
    logic [IDW-1:0] first_s, second_s;

    // A requester already holding a channel, or just preempted, cannot win this cycle.
    assign elig_s = req & ~gnt_vec_r & ~bar_r;

    dual_prio_enc #(.N(N), .IDW(IDW)) u_enc (
        .vec    (elig_s),
        .first  (first_s),
        .second (second_s)
    );

    // Allocation steering plus next-state logic for both channel FSMs.
    always_comb begin
        if (state_r[0] == IDLE) begin
            alloc_id_s[0] = first_s;
            alloc_id_s[1] = second_s;
        end else begin
            alloc_id_s[0] = IDW'(ID_NONE);
            alloc_id_s[1] = first_s;
        end
        bar_nx_s     = '0;
        timeout_nx_s = 2'b00;
        gnt_vec_nx_s = '0;
        held_oh_s    = '0;
        for (int ch = 0; ch < 2; ch++) begin
            state_nx_s[ch] = state_r[ch];
            id_nx_s[ch]    = id_r[ch];
            cnt_nx_s[ch]   = cnt_r[ch];
            held_oh_s      = N'(id_to_onehot(MAX_IDW'(id_r[ch])));
            case (state_r[ch])
                IDLE: begin
                    if (alloc_id_s[ch] != IDW'(ID_NONE)) begin
                        state_nx_s[ch] = BUSY;
                        id_nx_s[ch]    = alloc_id_s[ch];
                        cnt_nx_s[ch]   = '0;
                    end else begin
                        state_nx_s[ch] = IDLE;
                    end
                end
                BUSY: begin
                    // A normal release wins over the hold limit, so no timeout on coincidence.
                    if (((done & held_oh_s) != '0) || ((req & held_oh_s) == '0)) begin
                        state_nx_s[ch] = IDLE;
                        id_nx_s[ch]    = IDW'(ID_NONE);
                        cnt_nx_s[ch]   = '0;
                    end else if (cnt_r[ch] == CNT_LAST) begin
                        state_nx_s[ch]   = IDLE;
                        id_nx_s[ch]      = IDW'(ID_NONE);
                        cnt_nx_s[ch]     = '0;
                        timeout_nx_s[ch] = 1'b1;
                        bar_nx_s         = bar_nx_s | held_oh_s;
                    end else begin
                        cnt_nx_s[ch] = cnt_r[ch] + CNT_W'(1);
                    end
                end
                default: begin
                    state_nx_s[ch] = IDLE;
                    id_nx_s[ch]    = IDW'(ID_NONE);
                    cnt_nx_s[ch]   = '0;
                end
            endcase
            gnt_vec_nx_s = gnt_vec_nx_s | N'(id_to_onehot(MAX_IDW'(id_nx_s[ch])));
        end
    end

    // Channel state, counters, bar mask and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < 2; ch++) begin
                state_r[ch] <= IDLE;
                id_r[ch]    <= IDW'(ID_NONE);
                cnt_r[ch]   <= '0;
            end
            bar_r     <= '0;
            gnt_vec_r <= '0;
            timeout_r <= 2'b00;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                state_r[ch] <= state_nx_s[ch];
                id_r[ch]    <= id_nx_s[ch];
                cnt_r[ch]   <= cnt_nx_s[ch];
            end
            bar_r     <= bar_nx_s;
            gnt_vec_r <= gnt_vec_nx_s;
            timeout_r <= timeout_nx_s;
        end
    end

    assign gnt_a_vld = (state_r[0] == BUSY);
    assign gnt_a_id  = id_r[0];
    assign gnt_b_vld = (state_r[1] == BUSY);
    assign gnt_b_id  = id_r[1];
    assign gnt_vec   = gnt_vec_r;
    assign timeout   = timeout_r;

endmodule

// File: tb/tb_dual_grant_arbiter.sv
// Directed self-checking bench for dual_grant_arbiter (N=12, MAX_HOLD=16).
module tb_dual_grant_arbiter;

    localparam int N   = 12;
    localparam int IDW = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N-1:0]   done;
    logic           gnt_a_vld, gnt_b_vld;
    logic [IDW-1:0] gnt_a_id, gnt_b_id;
    logic [N-1:0]   gnt_vec;
    logic [1:0]     timeout;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dual_grant_arbiter #(.N(12), .IDW(4), .MAX_HOLD(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt_a_vld (gnt_a_vld),
        .gnt_a_id  (gnt_a_id),
        .gnt_b_vld (gnt_b_vld),
        .gnt_b_id  (gnt_b_id),
        .gnt_vec   (gnt_vec),
        .timeout   (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic av, input logic [3:0] aid,
                           input logic bv, input logic [3:0] bid,
                           input logic [11:0] vec, input logic [1:0] to);
        chk({tag, ".a_vld"},   32'(gnt_a_vld), 32'(av));
        chk({tag, ".a_id"},    32'(gnt_a_id),  32'(aid));
        chk({tag, ".b_vld"},   32'(gnt_b_vld), 32'(bv));
        chk({tag, ".b_id"},    32'(gnt_b_id),  32'(bid));
        chk({tag, ".gnt_vec"}, 32'(gnt_vec),   32'(vec));
        chk({tag, ".timeout"}, 32'(timeout),   32'(to));
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1;
        req   = 12'hFFF;
        done  = 12'h000;
        #2 rst_n = 1'b0;
        tick();
        tick();
        chk_all("reset", 1'b0, 4'd0, 1'b0, 4'd0, 12'h000, 2'b00);

        rst_n = 1'b1;
        tick();
        chk_all("por_grant", 1'b1, 4'd12, 1'b1, 4'd11, 12'hC00, 2'b00);

        req = 12'h000;
        tick();
        chk_all("drop_all", 1'b0, 4'd0, 1'b0, 4'd0, 12'h000, 2'b00);

        req = 12'h010;
        tick();
        chk_all("id5", 1'b1, 4'd5, 1'b0, 4'd0, 12'h010, 2'b00);
        done = 12'h010;
        tick();
        done = 12'h000;
        chk_all("done5", 1'b0, 4'd0, 1'b0, 4'd0, 12'h000, 2'b00);
        tick();
        chk_all("regrant5", 1'b1, 4'd5, 1'b0, 4'd0, 12'h010, 2'b00);
        done = 12'h001;
        tick();
        done = 12'h000;
        chk_all("stray_done", 1'b1, 4'd5, 1'b0, 4'd0, 12'h010, 2'b00);
        req = 12'h000;
        tick();
        chk_all("idle1", 1'b0, 4'd0, 1'b0, 4'd0, 12'h000, 2'b00);

        req = 12'hC00;
        tick();
        chk_all("busy_12_11", 1'b1, 4'd12, 1'b1, 4'd11, 12'hC00, 2'b00);
        req = 12'hC01;
        tick();
        chk_all("no_grant_1", 1'b1, 4'd12, 1'b1, 4'd11, 12'hC00, 2'b00);
        req = 12'h801;
        tick();
        chk_all("drop11", 1'b1, 4'd12, 1'b0, 4'd0, 12'h800, 2'b00);
        tick();
        chk_all("b_gets_1", 1'b1, 4'd12, 1'b1, 4'd1, 12'h801, 2'b00);
        req = 12'h000;
        tick();
        chk_all("idle2", 1'b0, 4'd0, 1'b0, 4'd0, 12'h000, 2'b00);

        req = 12'h080;
        tick();
        chk_all("hold8_c1", 1'b1, 4'd8, 1'b0, 4'd0, 12'h080, 2'b00);
        for (int k = 2; k <= 16; k++) begin
            tick();
            chk_all("hold8", 1'b1, 4'd8, 1'b0, 4'd0, 12'h080, 2'b00);
        end
        tick();
        chk_all("timeout_a", 1'b0, 4'd0, 1'b0, 4'd0, 12'h000, 2'b01);
        tick();
        chk_all("bar8", 1'b0, 4'd0, 1'b0, 4'd0, 12'h000, 2'b00);
        tick();
        chk_all("regrant8", 1'b1, 4'd8, 1'b0, 4'd0, 12'h080, 2'b00);
        req = 12'h000;
        tick();
        chk_all("idle3", 1'b0, 4'd0, 1'b0, 4'd0, 12'h000, 2'b00);

        req = 12'h0C0;
        tick();
        chk_all("pair_8_7", 1'b1, 4'd8, 1'b1, 4'd7, 12'h0C0, 2'b00);
        for (int k = 2; k <= 16; k++) begin
            tick();
            chk_all("pair_hold", 1'b1, 4'd8, 1'b1, 4'd7, 12'h0C0, 2'b00);
        end
        done = 12'h040;
        tick();
        done = 12'h000;
        chk_all("done_at_limit", 1'b0, 4'd0, 1'b0, 4'd0, 12'h000, 2'b01);
        tick();
        chk_all("bar_skip8", 1'b1, 4'd7, 1'b0, 4'd0, 12'h040, 2'b00);
        tick();
        chk_all("b_gets_8", 1'b1, 4'd7, 1'b1, 4'd8, 12'h0C0, 2'b00);

        #2 rst_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 4'd0, 1'b0, 4'd0, 12'h000, 2'b00);
        req = 12'hFFF;
        tick();
        chk_all("rst_hold", 1'b0, 4'd0, 1'b0, 4'd0, 12'h000, 2'b00);
        rst_n = 1'b1;
        tick();
        chk_all("restart", 1'b1, 4'd12, 1'b1, 4'd11, 12'hC00, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
